alu_issue_stage: RTL and testbench

- ID/EX issue stage that decodes LEGv8 opcodes into operand pairs and a 4-bit ALU select for the 64-bit ALU.
- Supported selects: 0000 AND, 0001 OR, 0010 ADD; every other select yields a zero result.
- The stage synthesises subtraction as ADD with a two's-complement B, and CBZ as OR with zero so the ALU z flag resolves the branch.
- Valid/ready on both sides, with a 2-entry skid buffer so in_ready is a register output; flush support for branch mispredicts.

---
 rtl/alu_issue_stage.sv | 109 ++++++++++
 tb/tb_alu_issue_stage.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes LEGv8 opcodes into ALU operands/select, with a
// 2-entry skid buffer (main M drives outputs, skid S absorbs one stalled beat).
module alu_issue_stage #(
    parameter int ANCHO = 64,
    parameter int OPW   = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   opcode,
    input  logic [ANCHO-1:0] rn_data,
    input  logic [ANCHO-1:0] rm_data,
    input  logic [ANCHO-1:0] imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ANCHO-1:0] A,
    output logic [ANCHO-1:0] B,
    output logic [3:0]       ALU_Sel,
    output logic             illegal
);

    localparam logic [3:0] SEL_AND = 4'b0000;
    localparam logic [3:0] SEL_OR  = 4'b0001;
    localparam logic [3:0] SEL_ADD = 4'b0010;

    typedef struct packed {
        logic [ANCHO-1:0] a;
        logic [ANCHO-1:0] b;
        logic [3:0]       sel;
        logic             ill;
    } ent_t;

    ent_t             w_dec;
    logic [ANCHO-1:0] w_neg_rm;
    logic [ANCHO-1:0] w_neg_imm;
    logic             w_acc;
    logic             w_m_free;
    logic             w_s_vld_nxt;

    ent_t r_m;
    ent_t r_s;
    logic r_m_vld;
    logic r_s_vld;
    logic r_in_ready;

    // Two's-complement negation wraps at ANCHO bits, so -0 = 0 and -MIN = MIN.
    assign w_neg_rm  = ~rm_data + ANCHO'(1);
    assign w_neg_imm = ~imm + ANCHO'(1);

    always_comb begin
        w_dec = '0;
        casez (opcode)
            11'b10001011000: begin w_dec.a = rn_data; w_dec.b = rm_data;   w_dec.sel = SEL_ADD; end
            11'b11001011000: begin w_dec.a = rn_data; w_dec.b = w_neg_rm;  w_dec.sel = SEL_ADD; end
            11'b10001010000: begin w_dec.a = rn_data; w_dec.b = rm_data;   w_dec.sel = SEL_AND; end
            11'b10101010000: begin w_dec.a = rn_data; w_dec.b = rm_data;   w_dec.sel = SEL_OR;  end
            11'b1001000100?: begin w_dec.a = rn_data; w_dec.b = imm;       w_dec.sel = SEL_ADD; end
            11'b1101000100?: begin w_dec.a = rn_data; w_dec.b = w_neg_imm; w_dec.sel = SEL_ADD; end
            11'b11111000010,
            11'b11111000000: begin w_dec.a = rn_data; w_dec.b = imm;       w_dec.sel = SEL_ADD; end
            // CBZ: Rt OR 0 lets the ALU zero flag resolve the branch.
            11'b10110100???: begin w_dec.a = rm_data; w_dec.b = '0;        w_dec.sel = SEL_OR;  end
            default:         w_dec.ill = 1'b1;
        endcase
    end

    assign w_acc       = in_valid && r_in_ready;
    assign w_m_free    = !r_m_vld || out_ready;
    assign w_s_vld_nxt = w_m_free ? (r_s_vld && w_acc) : (r_s_vld || w_acc);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_m        <= '0;
            r_s        <= '0;
            r_m_vld    <= 1'b0;
            r_s_vld    <= 1'b0;
            r_in_ready <= 1'b1;
        end else if (flush) begin
            r_m_vld    <= 1'b0;
            r_s_vld    <= 1'b0;
            r_in_ready <= 1'b1;
        end else begin
            if (w_m_free) begin
                if (r_s_vld) begin
                    r_m     <= r_s;
                    r_m_vld <= 1'b1;
                    if (w_acc) r_s <= w_dec;
                end else begin
                    r_m_vld <= w_acc;
                    if (w_acc) r_m <= w_dec;
                end
            end else if (w_acc) begin
                r_s <= w_dec;
            end
            r_s_vld    <= w_s_vld_nxt;
            r_in_ready <= !w_s_vld_nxt;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_m_vld;
    assign A         = r_m.a;
    assign B         = r_m.b;
    assign ALU_Sel   = r_m.sel;
    assign illegal   = r_m.ill;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: expected entries queue on accept and are
// checked (including the resulting ALU value) when EX drains them.
module tb_alu_issue_stage;

    localparam int ANCHO = 64;
    localparam int OPW   = 11;

    localparam logic [OPW-1:0] OP_ADD  = 11'b10001011000;
    localparam logic [OPW-1:0] OP_SUB  = 11'b11001011000;
    localparam logic [OPW-1:0] OP_AND  = 11'b10001010000;
    localparam logic [OPW-1:0] OP_ORR  = 11'b10101010000;
    localparam logic [OPW-1:0] OP_ADDI = 11'b10010001001;
    localparam logic [OPW-1:0] OP_SUBI = 11'b11010001000;
    localparam logic [OPW-1:0] OP_LDUR = 11'b11111000010;
    localparam logic [OPW-1:0] OP_STUR = 11'b11111000000;
    localparam logic [OPW-1:0] OP_CBZ  = 11'b10110100101;

    logic             clk = 1'b0;
    logic             reset, flush, in_valid, in_ready, out_valid, out_ready, illegal;
    logic [OPW-1:0]   opcode;
    logic [ANCHO-1:0] rn_data, rm_data, imm, A, B;
    logic [3:0]       ALU_Sel;

    typedef struct packed {
        logic [ANCHO-1:0] a;
        logic [ANCHO-1:0] b;
        logic [3:0]       sel;
        logic             ill;
        logic [ANCHO-1:0] res;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   n_cmp = 0;
    int   n_bad = 0;

    alu_issue_stage #(.ANCHO(ANCHO), .OPW(OPW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .rn_data(rn_data), .rm_data(rm_data), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .A(A), .B(B), .ALU_Sel(ALU_Sel), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [ANCHO-1:0] alu(input logic [ANCHO-1:0] a, input logic [ANCHO-1:0] b,
                                             input logic [3:0] s);
        case (s)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            default: return '0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [ANCHO-1:0] obs, input logic [ANCHO-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Checks a drain just before the edge, then records an accept at that edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (!reset && !flush && out_valid && out_ready) begin
            chk("scoreboard_nonempty", ANCHO'(q.size() != 0), ANCHO'(1));
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("A", A, e.a);
                chk("B", B, e.b);
                chk("ALU_Sel", ANCHO'(ALU_Sel), ANCHO'(e.sel));
                chk("illegal", ANCHO'(illegal), ANCHO'(e.ill));
                chk("alu_result", alu(A, B, ALU_Sel), e.res);
            end
        end
        if (reset || flush) q.delete();
        else if (in_valid && in_ready) q.push_back(cur);
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [OPW-1:0] op, input logic [ANCHO-1:0] rn, input logic [ANCHO-1:0] rm,
                           input logic [ANCHO-1:0] im, input logic [ANCHO-1:0] ea, input logic [ANCHO-1:0] eb,
                           input logic [3:0] es, input logic ei, input logic [ANCHO-1:0] er);
        opcode = op; rn_data = rn; rm_data = rm; imm = im; in_valid = 1'b1;
        cur.a = ea; cur.b = eb; cur.sel = es; cur.ill = ei; cur.res = er;
    endtask

    initial begin
        logic acc;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        opcode = '0; rn_data = '0; rm_data = '0; imm = '0; cur = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_out_valid", ANCHO'(out_valid), '0);
        chk("rst_in_ready", ANCHO'(in_ready), ANCHO'(1));
        chk("rst_A", A, '0);
        chk("rst_B", B, '0);
        chk("rst_sel", ANCHO'(ALU_Sel), '0);
        chk("rst_illegal", ANCHO'(illegal), '0);

        // Single-issue decode cases, one cycle latency each.
        out_ready = 1'b1;
        present(OP_ADD, 64'd5, 64'd7, 64'd0, 64'd5, 64'd7, 4'b0010, 1'b0, 64'd12);
        tick(); in_valid = 1'b0;
        chk("latency_out_valid", ANCHO'(out_valid), ANCHO'(1));
        chk("latency_A", A, 64'd5);
        tick();
        chk("idle_out_valid", ANCHO'(out_valid), '0);

        present(OP_SUB, 64'd3, 64'd5, 64'd0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 4'b0010, 1'b0,
                64'hFFFF_FFFF_FFFF_FFFE);
        tick();
        present(OP_SUBI, 64'h10, 64'd99, 64'd0, 64'h10, 64'd0, 4'b0010, 1'b0, 64'h10);
        tick();
        present(OP_CBZ, 64'h55, 64'd0, 64'd7, 64'd0, 64'd0, 4'b0001, 1'b0, 64'd0);
        tick();
        present(OP_CBZ, 64'h55, 64'd9, 64'd7, 64'd9, 64'd0, 4'b0001, 1'b0, 64'd9);
        tick();
        present(OP_SUB, 64'd0, 64'h8000_0000_0000_0000, 64'd0, 64'd0, 64'h8000_0000_0000_0000, 4'b0010,
                1'b0, 64'h8000_0000_0000_0000);
        tick();
        present(OP_ADDI, 64'd100, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd100, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0010,
                1'b0, 64'd99);
        tick();
        present(OP_LDUR, 64'h1000, 64'd1, 64'h18, 64'h1000, 64'h18, 4'b0010, 1'b0, 64'h1018);
        tick();
        present(OP_STUR, 64'h2000, 64'd1, 64'h8, 64'h2000, 64'h8, 4'b0010, 1'b0, 64'h2008);
        tick();
        present(OP_AND, 64'hF0F0, 64'hFF00, 64'd0, 64'hF0F0, 64'hFF00, 4'b0000, 1'b0, 64'hF000);
        tick();
        present(OP_ORR, 64'hF0F0, 64'h0F0F, 64'd0, 64'hF0F0, 64'h0F0F, 4'b0001, 1'b0, 64'hFFFF);
        tick();
        present(11'b00000000000, 64'h77, 64'h66, 64'h55, 64'd0, 64'd0, 4'b0000, 1'b1, 64'd0);
        tick(); in_valid = 1'b0;
        tick();
        chk("single_drained", ANCHO'(q.size()), '0);

        // Backpressure: two accepts fill M and S, third waits.
        out_ready = 1'b0;
        present(OP_ADD, 64'd1, 64'd1, 64'd0, 64'd1, 64'd1, 4'b0010, 1'b0, 64'd2);
        tick();
        present(OP_AND, 64'd6, 64'd3, 64'd0, 64'd6, 64'd3, 4'b0000, 1'b0, 64'd2);
        tick();
        chk("bp_in_ready_low", ANCHO'(in_ready), '0);
        present(OP_ORR, 64'd4, 64'd1, 64'd0, 64'd4, 64'd1, 4'b0001, 1'b0, 64'd5);
        tick();
        chk("bp_hold_A", A, 64'd1);
        chk("bp_hold_sel", ANCHO'(ALU_Sel), ANCHO'(4'b0010));
        chk("bp_queued", ANCHO'(q.size()), ANCHO'(2));
        out_ready = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 10 && !acc; i++) begin
            acc = in_ready;
            tick();
        end
        in_valid = 1'b0;
        chk("bp_third_accepted", ANCHO'(acc), ANCHO'(1));
        for (int i = 0; i < 10 && q.size() != 0; i++) tick();
        chk("bp_drained", ANCHO'(q.size()), '0);
        tick();
        chk("bp_empty_after", ANCHO'(out_valid), '0);

        // Flush with both entries full and a same-cycle request.
        out_ready = 1'b0;
        present(OP_ADD, 64'd1, 64'd2, 64'd0, 64'd1, 64'd2, 4'b0010, 1'b0, 64'd3);
        tick();
        present(OP_AND, 64'd1, 64'd2, 64'd0, 64'd1, 64'd2, 4'b0000, 1'b0, 64'd0);
        tick();
        present(OP_ORR, 64'd8, 64'd8, 64'd0, 64'd8, 64'd8, 4'b0001, 1'b0, 64'd8);
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", ANCHO'(out_valid), '0);
        chk("flush_in_ready", ANCHO'(in_ready), ANCHO'(1));
        out_ready = 1'b1;
        present(OP_ADD, 64'd10, 64'd20, 64'd0, 64'd10, 64'd20, 4'b0010, 1'b0, 64'd30);
        tick(); in_valid = 1'b0;
        chk("post_flush_valid", ANCHO'(out_valid), ANCHO'(1));
        tick();
        chk("post_flush_drained", ANCHO'(q.size()), '0);

        // Reset mid-stream.
        out_ready = 1'b0;
        present(OP_ADD, 64'd3, 64'd4, 64'd0, 64'd3, 64'd4, 4'b0010, 1'b0, 64'd7);
        tick();
        present(OP_ORR, 64'd3, 64'd4, 64'd0, 64'd3, 64'd4, 4'b0001, 1'b0, 64'd7);
        tick();
        reset = 1'b1; in_valid = 1'b0;
        tick();
        reset = 1'b0;
        chk("mrst_out_valid", ANCHO'(out_valid), '0);
        chk("mrst_in_ready", ANCHO'(in_ready), ANCHO'(1));
        chk("mrst_A", A, '0);
        chk("mrst_B", B, '0);
        chk("mrst_sel", ANCHO'(ALU_Sel), '0);
        chk("mrst_illegal", ANCHO'(illegal), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
